// File: rtl/spi_8363_pkg.sv
// spi_8363_pkg
//   Shared types and constants for the 8363 AGC SPI responder.
//   state_t    : frame decoder states
//   CMD_BITS   : bits in the command byte (R/W + address)
//   FRAME_BITS : total bits in one frame
//   RW_READ    : value of the R/W bit that selects a read
package spi_8363_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA,
      HOLD
   } state_t;

   localparam int   CMD_BITS   = 8;
   localparam int   FRAME_BITS = 16;
   localparam logic RW_READ    = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchronizer with one-cycle rise/fall pulses on the synced value.
//   i_clk   : sampling clock
//   i_rst_n : async active-low reset
//   i_d     : asynchronous input
//   o_sync  : synchronized level
//   o_rise  : one-cycle pulse on a synced 0->1
//   o_fall  : one-cycle pulse on a synced 1->0
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   // Reset to the line's idle level so leaving reset is not seen as an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_dly  <= RST_VAL;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_dly <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_rise =  o_sync & ~r_dly;
   assign o_fall = ~o_sync &  r_dly;

endmodule

// File: rtl/spi_slave_8363.sv
// spi_slave_8363
//   3-wire SPI responder modelling the 8363 AGC register interface.
//   Frames are 16 bits MSB first, sampled on SCLK rise: R/W, 7-bit address,
//   8-bit data. Reads are driven back on SDIO via sdio_oe/sdio_out.
//   main_clk  : system clock (SCLK <= main_clk/8)
//   reset     : async active-low reset
//   sclk/csb  : SPI clock (idle low) / chip select (active low)
//   sdio_in   : SDIO pin value from IOBUF O
//   sdio_out  : SDIO drive value to IOBUF I
//   sdio_oe   : 1 = responder drives SDIO (IOBUF T = ~sdio_oe)
//   reg_out   : flat register file, reg k at [k*DATA_W +: DATA_W]
//   wr_stb    : one-cycle pulse per committed write
//   wr_addr   : address of last committed write
//   wr_data   : data of last committed write
//   frame_err : one-cycle pulse when CSB rises mid-frame
module spi_slave_8363
   import spi_8363_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int NUM_REGS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       main_clk,
   input  logic                       reset,
   input  logic                       sclk,
   input  logic                       csb,
   input  logic                       sdio_in,
   output logic                       sdio_out,
   output logic                       sdio_oe,
   output logic [NUM_REGS*DATA_W-1:0] reg_out,
   output logic                       wr_stb,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       frame_err
);

   localparam int CNT_W = $clog2(FRAME_BITS);

   state_t                           r_state, w_state_nxt;
   logic [CNT_W-1:0]                 r_bitcnt;
   logic [DATA_W-1:0]                r_shift;
   logic [DATA_W-1:0]                r_rdsh;
   logic [ADDR_W-1:0]                r_addr;
   logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
   logic [SYNC_STAGES-1:0]           r_sdio_sync;
   logic                             r_oe;
   logic                             r_sdo;
   logic                             r_wr_stb;
   logic [ADDR_W-1:0]                r_wr_addr;
   logic [DATA_W-1:0]                r_wr_data;
   logic                             r_frame_err;

   logic                             w_unused_sclk_s;
   logic                             w_sclk_rise, w_sclk_fall;
   logic                             w_csb_s, w_csb_rise, w_csb_fall;
   logic                             w_sdio;
   logic [DATA_W-1:0]                w_shift_nxt;
   logic [ADDR_W-1:0]                w_cmd_addr;
   logic                             w_cmd_rw;
   logic                             w_cmd_last, w_data_last;
   logic [DATA_W-1:0]                w_rd_val;
   logic                             w_wr_hit;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .i_clk   (main_clk),
      .i_rst_n (reset),
      .i_d     (sclk),
      .o_sync  (w_unused_sclk_s),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
      .i_clk   (main_clk),
      .i_rst_n (reset),
      .i_d     (csb),
      .o_sync  (w_csb_s),
      .o_rise  (w_csb_rise),
      .o_fall  (w_csb_fall)
   );

   // Same depth as the sclk path so data and edge stay aligned.
   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) begin
         r_sdio_sync <= '0;
      end else begin
         r_sdio_sync[0] <= sdio_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sdio_sync[i] <= r_sdio_sync[i-1];
      end
   end
   assign w_sdio = r_sdio_sync[SYNC_STAGES-1];

   assign w_shift_nxt = {r_shift[DATA_W-2:0], w_sdio};
   assign w_cmd_rw    = w_shift_nxt[CMD_BITS-1];
   assign w_cmd_addr  = w_shift_nxt[ADDR_W-1:0];
   assign w_cmd_last  = w_sclk_rise && (r_bitcnt == CNT_W'(CMD_BITS-1));
   assign w_data_last = w_sclk_rise && (r_bitcnt == CNT_W'(DATA_W-1));

   // Address decode: out-of-range addresses read 0 and never write.
   always_comb begin
      w_rd_val = '0;
      w_wr_hit = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_cmd_addr == ADDR_W'(k)) w_rd_val = r_regs[k];
         if (r_addr == ADDR_W'(k))     w_wr_hit = 1'b1;
      end
   end

   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // CSB rise is checked first so it wins over a coincident 16th SCLK rise.
   always_comb begin
      w_state_nxt = r_state;
      if (w_csb_rise) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_csb_fall) w_state_nxt = CMD;
            CMD:     if (w_cmd_last) w_state_nxt = (w_cmd_rw == RW_READ) ? RDATA : WDATA;
            WDATA:   if (w_data_last) w_state_nxt = HOLD;
            RDATA:   if (w_data_last) w_state_nxt = HOLD;
            HOLD:    w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge main_clk or negedge reset) begin
      if (!reset) begin
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_rdsh      <= '0;
         r_addr      <= '0;
         r_regs      <= '0;
         r_oe        <= 1'b0;
         r_sdo       <= 1'b0;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_stb    <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_csb_rise) begin
            r_oe     <= 1'b0;
            r_bitcnt <= '0;
            if (r_state inside {CMD, WDATA, RDATA}) r_frame_err <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_csb_fall) begin
                     r_bitcnt <= '0;
                     r_shift  <= '0;
                     r_sdo    <= 1'b0;
                  end
               end
               CMD: begin
                  if (w_sclk_rise) begin
                     r_shift  <= w_shift_nxt;
                     r_bitcnt <= w_cmd_last ? '0 : r_bitcnt + 1'b1;
                     if (w_cmd_last) begin
                        r_addr <= w_cmd_addr;
                        r_rdsh <= w_rd_val;
                     end
                  end
               end
               WDATA: begin
                  if (w_sclk_rise) begin
                     r_shift  <= w_shift_nxt;
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (w_data_last && w_wr_hit) begin
                        for (int k = 0; k < NUM_REGS; k++)
                           if (r_addr == ADDR_W'(k)) r_regs[k] <= w_shift_nxt;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_shift_nxt;
                        r_wr_stb  <= 1'b1;
                     end
                  end
               end
               RDATA: begin
                  // Each fall presents the next bit; the first one also opens the driver.
                  if (w_sclk_fall) begin
                     r_oe   <= 1'b1;
                     r_sdo  <= r_rdsh[DATA_W-1];
                     r_rdsh <= {r_rdsh[DATA_W-2:0], 1'b0};
                  end
                  if (w_sclk_rise) r_bitcnt <= r_bitcnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign reg_out   = r_regs;
   assign sdio_out  = r_sdo;
   // Gate with synced CSB so the driver drops the cycle CSB is seen high.
   assign sdio_oe   = r_oe & ~w_csb_s;
   assign wr_stb    = r_wr_stb;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_8363.sv
module tb_spi_slave_8363;

   localparam int HC = 8;  // main_clk cycles per SCLK half period

   logic         main_clk = 1'b0;
   logic         reset    = 1'b0;
   logic         sclk     = 1'b0;
   logic         csb      = 1'b1;
   logic         drv      = 1'b0;
   logic         w_pin;
   logic         sdio_out, sdio_oe;
   logic [127:0] reg_out;
   logic         wr_stb;
   logic [6:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         frame_err;

   int n_chk  = 0;
   int n_fail = 0;
   int n_stb  = 0;
   int n_ferr = 0;

   logic [15:0][7:0] m_regs;

   always #5 main_clk = ~main_clk;

   // IOBUF model: pin follows the responder when it drives, else the master.
   assign w_pin = sdio_oe ? sdio_out : drv;

   spi_slave_8363 dut (
      .main_clk  (main_clk),
      .reset     (reset),
      .sclk      (sclk),
      .csb       (csb),
      .sdio_in   (w_pin),
      .sdio_out  (sdio_out),
      .sdio_oe   (sdio_oe),
      .reg_out   (reg_out),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   always @(negedge main_clk) begin
      if (wr_stb)    n_stb++;
      if (frame_err) n_ferr++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge main_clk);
   endtask

   // Master: nrise SCLK pulses; bits past 16 drive 1. Captures data-phase pin.
   task automatic spi_frame(input logic [15:0] w, input int nrise, input bit raise_csb,
                            output logic [7:0] rd, output logic oe_at_data);
      rd = '0;
      oe_at_data = 1'b0;
      csb = 1'b0;
      for (int i = 0; i < nrise; i++) begin
         drv = (i < 16) ? w[15-i] : 1'b1;
         cyc(HC);
         sclk = 1'b1;
         if (i == 8) oe_at_data = sdio_oe;
         if (i >= 8 && i < 16) rd = {rd[6:0], w_pin};
         cyc(HC);
         sclk = 1'b0;
      end
      if (raise_csb) begin
         cyc(HC);
         csb = 1'b1;
         drv = 1'b0;
         cyc(4*HC);
      end
   endtask

   initial begin
      logic [7:0] rd;
      logic       oe_d;
      int         s0, f0;

      m_regs = '0;
      cyc(3);
      check("rst_oe", sdio_oe, 1'b0);
      check("rst_out", sdio_out, 1'b0);
      check("rst_regs", reg_out, '0);
      check("rst_stb", wr_stb, 1'b0);
      check("rst_waddr", wr_addr, 7'h0);
      check("rst_wdata", wr_data, 8'h0);
      check("rst_ferr", frame_err, 1'b0);
      reset = 1'b1;
      cyc(8);

      // Write then read back
      s0 = n_stb;
      spi_frame(16'h03A5, 16, 1, rd, oe_d);
      m_regs[3] = 8'hA5;
      check("wr_stb_cnt", n_stb - s0, 1);
      check("wr_addr", wr_addr, 7'd3);
      check("wr_data", wr_data, 8'hA5);
      check("reg3", reg_out[31:24], 8'hA5);
      check("regs_after_wr", reg_out, m_regs);

      f0 = n_ferr;
      spi_frame(16'h8300, 16, 0, rd, oe_d);
      check("rd_oe_data", oe_d, 1'b1);
      check("rd_data", rd, 8'hA5);
      check("rd_oe_hold", sdio_oe, 1'b1);
      cyc(HC);
      csb = 1'b1;
      cyc(3);
      #1;
      check("rd_oe_release", sdio_oe, 1'b0);
      cyc(4*HC);
      check("rd_no_ferr", n_ferr - f0, 0);

      // Out-of-range address
      s0 = n_stb;
      spi_frame(16'h7F55, 16, 1, rd, oe_d);
      check("oor_stb", n_stb - s0, 0);
      check("oor_regs", reg_out, m_regs);
      spi_frame(16'hFF00, 16, 1, rd, oe_d);
      check("oor_rd", rd, 8'h00);

      // Mid-frame abort after 12 rises
      s0 = n_stb; f0 = n_ferr;
      spi_frame(16'h0142, 12, 1, rd, oe_d);
      check("abort_ferr", n_ferr - f0, 1);
      check("abort_stb", n_stb - s0, 0);
      check("abort_regs", reg_out, m_regs);
      spi_frame(16'h0142, 16, 1, rd, oe_d);
      m_regs[1] = 8'h42;
      check("after_abort_stb", n_stb - s0, 1);
      check("after_abort_reg1", reg_out[15:8], 8'h42);

      // Over-clocked frame: 20 rises
      s0 = n_stb; f0 = n_ferr;
      spi_frame(16'h0511, 20, 1, rd, oe_d);
      m_regs[5] = 8'h11;
      check("ovr_stb", n_stb - s0, 1);
      check("ovr_reg5", reg_out[47:40], 8'h11);
      check("ovr_regs", reg_out, m_regs);
      check("ovr_ferr", n_ferr - f0, 0);

      // Async reset during read data phase
      spi_frame(16'h8300, 12, 0, rd, oe_d);
      check("mid_rd_oe", sdio_oe, 1'b1);
      cyc(2);
      reset = 1'b0;
      #1;
      check("arst_oe", sdio_oe, 1'b0);
      check("arst_regs", reg_out, '0);
      check("arst_ferr", frame_err, 1'b0);
      m_regs = '0;
      csb = 1'b1;
      sclk = 1'b0;
      drv = 1'b0;
      cyc(4);
      reset = 1'b1;
      cyc(8);

      // Back-to-back writes, 2 SCLK periods of CSB high between frames
      s0 = n_stb;
      for (int k = 0; k < 4; k++) begin
         logic [15:0] w;
         w = {1'b0, 7'(k), 8'(8'h11 * (k + 1))};
         spi_frame(w, 16, 1, rd, oe_d);
      end
      check("b2b_stb", n_stb - s0, 4);
      check("b2b_regs", reg_out[31:0], 32'h44332211);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_8363.md
Name: spi_slave_8363

Overview:
3-wire SPI responder that models the 8363 AGC register interface, for loopback test and bench use against the SPI_AGC master. It oversamples SCLK/CSB/SDIO on main_clk, decodes 16-bit frames (R/W, 7-bit address, 8-bit data), and holds a register file. Written registers are exposed to the fabric. Reads are returned on the shared SDIO line via an output-enable, which is intended to drive the I/T pins of the top-level IOBUF.

Parameters:
DATA_W, 8, register data width and data-phase bit count
ADDR_W, 7, address field width
NUM_REGS, 16, implemented registers at addresses 0..NUM_REGS-1
SYNC_STAGES, 2, synchronizer depth on sclk, csb and sdio_in

Ports:
main_clk  in  1  system clock; SCLK must be ≤ main_clk/8
reset  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock from master; idle low
csb  in  1  chip select, active low
sdio_in  in  1  SDIO input, from the IOBUF O pin
sdio_out  out  1  SDIO drive value, to the IOBUF I pin
sdio_oe  out  1  1 = slave drives SDIO; IOBUF T = ~sdio_oe
reg_out  out  NUM_REGS*DATA_W  flat register file; reg k is at [k*DATA_W +: DATA_W]
wr_stb  out  1  one-cycle pulse when a register write commits
wr_addr  out  ADDR_W  address of the last committed write
wr_data  out  DATA_W  data of the last committed write
frame_err  out  1  one-cycle pulse when CSB rises mid-frame

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, state IDLE, sdio_oe=0, sdio_out=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, bit counter 0.
- Synchronization: sclk, csb and sdio_in each pass through SYNC_STAGES flops. Edges are detected on the synced sclk by comparing against a one-cycle-delayed copy.
- Edge decode latency: SYNC_STAGES+1 main_clk cycles from the pin edge.
- Frame format, MSB first, sampled on SCLK rising edge:
  - bit15 = R1W0
  - bits14..8 = address
  - bits7..0 = data
- FSM states: IDLE, CMD, WDATA, RDATA, HOLD.
  - IDLE -> CMD on synced csb falling edge; bit counter cleared; shift register cleared.
  - CMD: shift in 8 bits on sclk rises. After the 8th rise, latch R/W and address.
    - R/W = 0: go to WDATA.
    - R/W = 1: go to RDATA, load the read shift register with reg[addr], or 0x00 if addr ≥ NUM_REGS.
  - WDATA: shift in 8 bits. On the 8th rise, commit the write:
    - if addr < NUM_REGS, update reg[addr], load wr_addr/wr_data, and pulse wr_stb on the next cycle;
    - if addr ≥ NUM_REGS, discard the data and assert no wr_stb;
    - then go to HOLD.
  - RDATA:
    - sdio_oe rises on the first sclk falling edge after the 8th rise.
    - sdio_out presents the data MSB at that fall, then shifts one bit per subsequent fall.
    - After the 8th data bit has been presented and its following rise is seen, go to HOLD; sdio_oe stays 1.
  - HOLD: ignore further sclk edges (no wrap, no second transaction).
  - Any state -> IDLE on synced csb rising edge. sdio_oe is forced to 0 in the same cycle.
- Abort: csb rises in CMD/WDATA/RDATA before the 16th rise.
  - No register changes, wr_stb=0.
  - frame_err pulses 1 cycle.
  - Registers are never partially written.
- Reset mid-frame: immediate return to reset state; the current frame is lost.
- csb high: all sclk activity is ignored.
- Simultaneous csb rise and 16th sclk rise in the same synced cycle: csb wins; the frame counts as aborted and frame_err pulses.
- sdio_oe is never 1 while synced csb is 1, or in IDLE/CMD/WDATA.

Decomposition:
- Shared package spi_8363_pkg:
  - state typedef (IDLE, CMD, WDATA, RDATA, HOLD);
  - constants CMD_BITS=8, FRAME_BITS=16, RW_READ=1'b1.
- One sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for sclk and csb; sdio_in uses its synced value only.

Test Plan:
- Write then read-back: write frame 0x03A5 (W, addr 3, 0xA5).
  - Required: wr_stb pulses once, wr_addr=3, wr_data=0xA5, reg_out[31:24]=0xA5.
  - Then read frame 0x83xx: sdio_oe=1 from the 8th fall, master samples 0xA5, sdio_oe=0 within SYNC_STAGES+1 cycles after csb rises.
- Out-of-range address: write 0x7F55 -> no wr_stb, reg_out unchanged; read 0xFFxx -> returns 0x00.
- Mid-frame abort: csb rises after 12 sclk rises of write 0x0142 -> frame_err pulses once, reg1 unchanged, wr_stb=0, FSM back in IDLE; the next full write 0x0142 succeeds.
- Over-clocking: 20 sclk rises in one write frame 0x0511 -> reg5=0x11, exactly one wr_stb, extra bits ignored.
- Async reset mid-read: assert reset during the RDATA phase -> sdio_oe=0 immediately, all reg_out=0, frame_err=0.
- Back-to-back frames: 4 writes to regs 0..3 (0x11,0x22,0x33,0x44) with csb high for only 2 SCLK periods between frames -> all four commit, reg_out[31:0]=0x44332211.
